// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - NUM_PIPES scrolling pipe pairs with LFSR gaps, scoring and collision; caps under PIPE_CAP_EN
module pipe_field #(
  parameter int          NUM_PIPES = 3,
  parameter int          SCREEN_W  = 640,
  parameter int          PIPE_W    = 40,
  parameter int          GAP_H     = 120,
  parameter int          GAP_MIN   = 60,
  parameter int          GAP_MASK  = 255,
  parameter int          SPACING   = 240,
  parameter int          SPEED     = 2,
  parameter int          BIRD_SZ   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  input  logic [9:0] bird_x,
  input  logic [9:0] bird_y,
  output logic       pipe_pixel,
  output logic       pipe_cap,
  output logic [7:0] score,
  output logic       score_pulse,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DEAD = 2'b10;

  localparam logic [10:0] SPEED_W = 11'(SPEED);
  localparam logic [10:0] WRAP_W  = 11'(NUM_PIPES * SPACING);
  localparam logic [8:0]  GT_INIT = 9'(GAP_MIN + GAP_MASK / 2);
  localparam logic [8:0]  GMIN_W  = 9'(GAP_MIN);
  localparam logic [7:0]  GMASK_W = 8'(GAP_MASK);

  // Geometry is compared in 12 bits so that sums like h+PIPE_W never wrap.
  localparam logic [11:0] PW_E = 12'(PIPE_W);
  localparam logic [11:0] GH_E = 12'(GAP_H);
  localparam logic [11:0] BS_E = 12'(BIRD_SZ);

  logic [NUM_PIPES-1:0][10:0] rx;
  logic [NUM_PIPES-1:0][8:0]  gt;
  logic [15:0]                lfsr;
  logic [15:0]                lfsr_next;

  logic [NUM_PIPES-1:0][10:0] rx_move;
  logic [NUM_PIPES-1:0][8:0]  gt_move;
  logic [NUM_PIPES-1:0]       passed;
  logic [3:0]                 pass_cnt;
  logic [8:0]                 score_sum;
  logic [7:0]                 score_sat;

  logic [NUM_PIPES-1:0][11:0] rxe;
  logic [NUM_PIPES-1:0][11:0] gte;
  logic [NUM_PIPES-1:0]       body_hit;
  logic [NUM_PIPES-1:0]       body_px;
  logic                       hit;
  logic                       pix_next;

  logic [11:0] hx, vy, bx, by;

  assign hx = {2'b00, h_counter};
  assign vy = {2'b00, v_counter};
  assign bx = {2'b00, bird_x};
  assign by = {2'b00, bird_y};

  // Galois step: shift right, fold the taps back in when a one falls out.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Candidate positions after one frame of scrolling, with respawn and pass detection.
  always_comb begin
    rx_move = rx;
    gt_move = gt;
    passed  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (rx[i] <= SPEED_W) begin
        rx_move[i] = rx[i] - SPEED_W + WRAP_W;
        gt_move[i] = GMIN_W + {1'b0, lfsr[7:0] & GMASK_W};
      end else begin
        rx_move[i] = rx[i] - SPEED_W;
      end
      passed[i] = (rx[i] > {1'b0, bird_x}) && (rx_move[i] <= {1'b0, bird_x});
    end
  end

  // Saturating score after adding every pass of this frame.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pass_cnt = pass_cnt + {3'b000, passed[i]};
    end
    score_sum = {1'b0, score} + {5'b00000, pass_cnt};
    score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Body overlap against the bird box and against the current pixel.
  always_comb begin
    rxe      = '0;
    gte      = '0;
    body_hit = '0;
    body_px  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      rxe[i] = {1'b0, rx[i]};
      gte[i] = {3'b000, gt[i]};
      body_hit[i] = (bx < rxe[i]) && (bx + BS_E + PW_E > rxe[i]) &&
                    ((by < gte[i]) || (by + BS_E > gte[i] + GH_E));
      body_px[i]  = (hx < rxe[i]) && (hx + PW_E >= rxe[i]) &&
                    ((vy < gte[i]) || (vy >= gte[i] + GH_E));
    end
  end

`ifdef PIPE_CAP_EN
  localparam logic [11:0] CAP_X = 12'd4;
  localparam logic [11:0] CAP_Y = 12'd8;

  logic [NUM_PIPES-1:0] cap_hit;
  logic [NUM_PIPES-1:0] cap_px;
  logic                 cap_next;

  // Caps are 4 px wider on each side and 8 rows tall, hugging the gap.
  always_comb begin
    cap_hit = '0;
    cap_px  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      cap_hit[i] = (bx < rxe[i] + CAP_X) && (bx + BS_E + PW_E + CAP_X > rxe[i]) &&
                   (((by < gte[i]) && (by + BS_E + CAP_Y > gte[i])) ||
                    ((by < gte[i] + GH_E + CAP_Y) && (by + BS_E > gte[i] + GH_E)));
      cap_px[i]  = (hx < rxe[i] + CAP_X) && (hx + PW_E + CAP_X >= rxe[i]) &&
                   (((vy < gte[i]) && (vy + CAP_Y >= gte[i])) ||
                    ((vy >= gte[i] + GH_E) && (vy < gte[i] + GH_E + CAP_Y)));
    end
  end

  assign cap_next = |cap_px;
  assign hit      = (|body_hit) | (|cap_hit);

  // Cap pixel register, same latency as the body pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_cap <= 1'b0;
    end else begin
      pipe_cap <= cap_next;
    end
  end
`else
  assign hit      = |body_hit;
  assign pipe_cap = 1'b0;
`endif

  assign pix_next = |body_px;

  // Game FSM, pipe scrolling, scoring and the pixel register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        rx[i] <= 11'(SCREEN_W + PIPE_W + i * SPACING);
        gt[i] <= GT_INIT;
      end
      lfsr        <= LFSR_SEED;
      state       <= ST_IDLE;
      score       <= '0;
      score_pulse <= 1'b0;
      pipe_pixel  <= 1'b0;
    end else begin
      pipe_pixel  <= pix_next;
      score_pulse <= 1'b0;
      if (frame_tick) begin
        lfsr <= lfsr_next;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_tick) begin
            if (hit) begin
              state <= ST_DEAD;
            end else begin
              rx <= rx_move;
              gt <= gt_move;
              if (|passed) begin
                score       <= score_sat;
                score_pulse <= 1'b1;
              end
            end
          end
        end
        ST_DEAD: begin
          if (start) begin
            state <= ST_IDLE;
            score <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
              rx[i] <= 11'(SCREEN_W + PIPE_W + i * SPACING);
              gt[i] <= GT_INIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
